// File: rtl/simd_result_accumulator_pkg.sv
// Shared types for the SIMD multiplier result accumulator.
// Mode encodings, FSM states and lane count.
package simd_result_accumulator_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        MODE_16X16     = 2'b00,
        MODE_SUM_16X16 = 2'b01,
        MODE_SUM_8X8   = 2'b10,
        MODE_SUM_4X4   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        HOLD  = 2'b10
    } state_e;

endpackage

// File: rtl/simd_result_accumulator_unpack.sv
// Recombines a multiplier result pair into up to four lanes,
// sign- or zero-extended to the accumulator width.
module simd_result_unpack
    import simd_result_accumulator_pkg::*;
#(
    parameter int ACC_W = 48
) (
    input  logic [1:0]                  mode,
    input  logic                        in_signed,
    input  logic [31:0]                 result_0,
    input  logic [31:0]                 result_1,
    input  logic [3:0]                  carry,
    output logic [LANES-1:0][ACC_W-1:0] lane,
    output logic [LANES-1:0]            lane_en
);

    logic [31:0] sum32;
    logic [15:0] lo16;
    logic [15:0] hi16;
    logic [32:0] l33;
    logic [16:0] l17_0;
    logic [16:0] l17_1;
    logic [8:0]  l9_0;
    logic [8:0]  l9_1;
    logic [8:0]  l9_2;
    logic [8:0]  l9_3;

    assign sum32 = result_0 + result_1;
    assign lo16  = result_0[15:0] + result_1[15:0];
    assign hi16  = result_0[31:16] + result_1[31:16];
    assign l33   = {carry[3], sum32};
    assign l17_0 = {carry[1], lo16};
    assign l17_1 = {carry[3], hi16};
    // Even bytes come from word 0, odd bytes from word 1.
    assign l9_0  = {carry[0], result_0[7:0]};
    assign l9_1  = {carry[1], result_1[15:8]};
    assign l9_2  = {carry[2], result_0[23:16]};
    assign l9_3  = {carry[3], result_1[31:24]};

    always_comb begin
        lane    = '0;
        lane_en = '0;
        unique case (mode)
            MODE_16X16, MODE_SUM_16X16: begin
                lane_en = 4'b0001;
                lane[0] = in_signed ? ACC_W'($signed(l33)) : ACC_W'(l33);
            end
            MODE_SUM_8X8: begin
                lane_en = 4'b0011;
                lane[0] = in_signed ? ACC_W'($signed(l17_0)) : ACC_W'(l17_0);
                lane[1] = in_signed ? ACC_W'($signed(l17_1)) : ACC_W'(l17_1);
            end
            MODE_SUM_4X4: begin
                lane_en = 4'b1111;
                lane[0] = in_signed ? ACC_W'($signed(l9_0)) : ACC_W'(l9_0);
                lane[1] = in_signed ? ACC_W'($signed(l9_1)) : ACC_W'(l9_1);
                lane[2] = in_signed ? ACC_W'($signed(l9_2)) : ACC_W'(l9_2);
                lane[3] = in_signed ? ACC_W'($signed(l9_3)) : ACC_W'(l9_3);
            end
            default: begin
                lane    = '0;
                lane_en = '0;
            end
        endcase
    end

endmodule

// File: rtl/simd_result_accumulator.sv
// Accumulates SIMD multiplier lane results over a packet of beats
// and presents the lane sums on a valid/ready output.
module simd_result_accumulator
    import simd_result_accumulator_pkg::*;
#(
    parameter int ACC_W     = 48,
    parameter int MAX_BEATS = 256,
    parameter int CNT_W     = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_last,
    input  logic [1:0]         mode,
    input  logic               in_signed,
    input  logic [31:0]        result_0,
    input  logic [31:0]        result_1,
    input  logic [3:0]         result_SIDM_carry,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   acc_0,
    output logic [ACC_W-1:0]   acc_1,
    output logic [ACC_W-1:0]   acc_2,
    output logic [ACC_W-1:0]   acc_3,
    output logic [CNT_W-1:0]   out_beats,
    output logic [3:0]         overflow,
    output logic               mode_err
);

    state_e                     state;
    logic [1:0]                 mode_q;
    logic                       signed_q;
    logic [LANES-1:0][ACC_W-1:0] acc_q;
    logic [CNT_W-1:0]           cnt;
    logic [3:0]                 ovf_q;
    logic                       err_q;

    logic                       ext_signed;
    logic [LANES-1:0][ACC_W-1:0] lane;
    logic [LANES-1:0]           lane_en;
    logic [LANES-1:0][ACC_W:0]  sum;
    logic [LANES-1:0]           wrap;
    logic                       accept;
    logic [CNT_W-1:0]           cnt_nx;
    logic                       first_close;
    logic                       accum_close;

    // The first beat defines signedness for the whole packet.
    assign ext_signed = (state == IDLE) ? in_signed : signed_q;
    assign accept     = in_valid & in_ready;
    assign cnt_nx     = cnt + 1'b1;

    assign first_close = in_last || (mode == MODE_16X16) || (MAX_BEATS == 1);
    assign accum_close = in_last || (cnt_nx == CNT_W'(MAX_BEATS));

    simd_result_unpack #(
        .ACC_W (ACC_W)
    ) u_unpack (
        .mode      (mode),
        .in_signed (ext_signed),
        .result_0  (result_0),
        .result_1  (result_1),
        .carry     (result_SIDM_carry),
        .lane      (lane),
        .lane_en   (lane_en)
    );

    always_comb begin
        sum  = '0;
        wrap = '0;
        for (int k = 0; k < LANES; k++) begin
            sum[k] = {1'b0, acc_q[k]} + {1'b0, lane[k]};
            if (signed_q) begin
                wrap[k] = (acc_q[k][ACC_W-1] == lane[k][ACC_W-1]) &&
                          (sum[k][ACC_W-1] != acc_q[k][ACC_W-1]);
            end else begin
                wrap[k] = sum[k][ACC_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= MODE_16X16;
            signed_q  <= 1'b0;
            acc_q     <= '0;
            cnt       <= '0;
            ovf_q     <= '0;
            err_q     <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        mode_q   <= mode;
                        signed_q <= in_signed;
                        acc_q    <= lane;
                        cnt      <= CNT_W'(1);
                        ovf_q    <= '0;
                        err_q    <= 1'b0;
                        if (first_close) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        cnt <= cnt_nx;
                        if (mode == mode_q) begin
                            for (int k = 0; k < LANES; k++) begin
                                acc_q[k] <= sum[k][ACC_W-1:0];
                            end
                            ovf_q <= ovf_q | (wrap & lane_en);
                        end else begin
                            err_q <= 1'b1;
                        end
                        if (accum_close) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    in_ready <= 1'b0;
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign acc_0     = acc_q[0];
    assign acc_1     = acc_q[1];
    assign acc_2     = acc_q[2];
    assign acc_3     = acc_q[3];
    assign out_beats = cnt;
    assign overflow  = ovf_q;
    assign mode_err  = err_q;

endmodule

// File: tb/tb_simd_result_accumulator.sv
// Directed scoreboard bench for simd_result_accumulator
// (ACC_W=33, MAX_BEATS=4).
module tb_simd_result_accumulator;

    localparam int AW = 33;
    localparam int MB = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_last = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          in_signed = 1'b0;
    logic [31:0]   result_0 = '0;
    logic [31:0]   result_1 = '0;
    logic [3:0]    carry = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] acc_0, acc_1, acc_2, acc_3;
    logic [CW-1:0] out_beats;
    logic [3:0]    overflow;
    logic          mode_err;

    simd_result_accumulator #(
        .ACC_W(AW), .MAX_BEATS(MB), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .mode(mode), .in_signed(in_signed),
        .result_0(result_0), .result_1(result_1),
        .result_SIDM_carry(carry),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_0(acc_0), .acc_1(acc_1), .acc_2(acc_2), .acc_3(acc_3),
        .out_beats(out_beats), .overflow(overflow), .mode_err(mode_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a [4];
        int            beats;
        logic [3:0]    ovf;
        logic          err;
    } exp_t;

    exp_t sb [$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]    m_mode;
    bit            m_sgn;
    bit            m_active = 0;
    logic [AW-1:0] m_acc [4];
    int            m_cnt;
    logic [3:0]    m_ovf;
    bit            m_err;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] ext(logic [32:0] v, int w, bit s);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < AW; i++) begin
            if (i < w) r[i] = v[i];
            else r[i] = s & v[w-1];
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] mlane(logic [1:0] md, bit s,
            logic [31:0] r0, logic [31:0] r1, logic [3:0] c, int k);
        logic [31:0] t32;
        logic [15:0] t16;
        logic [32:0] v;
        v = '0;
        case (md)
            2'b00, 2'b01: begin
                if (k != 0) return '0;
                t32 = r0 + r1;
                v = {c[3], t32};
                return ext(v, 33, s);
            end
            2'b10: begin
                if (k > 1) return '0;
                if (k == 0) t16 = r0[15:0] + r1[15:0];
                else t16 = r0[31:16] + r1[31:16];
                v[16:0] = {(k == 0) ? c[1] : c[3], t16};
                return ext(v, 17, s);
            end
            default: begin
                case (k)
                    0: v[8:0] = {c[0], r0[7:0]};
                    1: v[8:0] = {c[1], r1[15:8]};
                    2: v[8:0] = {c[2], r0[23:16]};
                    default: v[8:0] = {c[3], r1[31:24]};
                endcase
                return ext(v, 9, s);
            end
        endcase
    endfunction

    function automatic longint as_int(logic [AW-1:0] v, bit s);
        longint x;
        x = longint'(v);
        if (s && v[AW-1]) x = x - (longint'(1) <<< AW);
        return x;
    endfunction

    // Drives one beat, models its effect and checks close latency.
    task automatic send(logic [1:0] md, bit s, logic [31:0] r0,
            logic [31:0] r1, logic [3:0] c, bit last);
        int n;
        bit close;
        logic [AW-1:0] l;
        longint sm;
        exp_t e;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1; mode = md; in_signed = s;
        result_0 = r0; result_1 = r1; carry = c; in_last = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(n < 50), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!m_active) begin
            m_active = 1; m_mode = md; m_sgn = s; m_cnt = 1;
            m_ovf = '0; m_err = 0;
            for (int k = 0; k < 4; k++) m_acc[k] = mlane(md, s, r0, r1, c, k);
            close = last || md == 2'b00 || MB == 1;
        end else begin
            m_cnt++;
            if (md != m_mode) m_err = 1;
            else for (int k = 0; k < 4; k++) begin
                l = mlane(md, m_sgn, r0, r1, c, k);
                sm = as_int(m_acc[k], m_sgn) + as_int(l, m_sgn);
                if (m_sgn ? (sm > (longint'(1) <<< (AW-1)) - 1 ||
                             sm < -(longint'(1) <<< (AW-1)))
                          : (sm > (longint'(1) <<< AW) - 1))
                    m_ovf[k] = 1'b1;
                m_acc[k] = m_acc[k] + l;
            end
            close = last || m_cnt == MB;
        end
        if (close) begin
            e.a = m_acc; e.beats = m_cnt; e.ovf = m_ovf; e.err = m_err;
            sb.push_back(e);
            m_active = 0;
            check("close_latency", 64'(out_valid), 64'd1);
        end
    endtask

    task automatic collect(int hold_cycles);
        int n;
        exp_t e;
        logic [AW-1:0] a0_ref;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("out_timeout", 64'(n < 50), 64'd1);
        check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        a0_ref = acc_0;
        for (int i = 0; i < hold_cycles; i++) begin
            @(negedge clk);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_stable", 64'(acc_0), 64'(a0_ref));
        end
        check("acc_0", 64'(acc_0), 64'(e.a[0]));
        check("acc_1", 64'(acc_1), 64'(e.a[1]));
        check("acc_2", 64'(acc_2), 64'(e.a[2]));
        check("acc_3", 64'(acc_3), 64'(e.a[3]));
        check("out_beats", 64'(out_beats), 64'(e.beats));
        check("overflow", 64'(overflow), 64'(e.ovf));
        check("mode_err", 64'(mode_err), 64'(e.err));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_valid", 64'(out_valid), 64'd0);
        check("release_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_acc_0", 64'(acc_0), 64'd0);
        check("rst_beats", 64'(out_beats), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 64'(in_ready), 64'd1);

        // Single 16x16 product: never accumulated.
        send(2'b00, 0, 32'h0000_1234, 32'h0001_0000, 4'h0, 0);
        check("m00_value", 64'(sb[0].a[0]), 64'h1_1234);
        collect(0);

        // Three signed 4x4 beats of -1 in lane 0, with backpressure.
        for (int b = 0; b < 3; b++)
            send(2'b11, 1, 32'h0000_00FF, 32'h0, 4'h1, b == 2);
        check("m11_value", 64'(sb[0].a[0]), 64'h1_FFFF_FFFD);
        collect(5);

        // Two unsigned 8x8 beats: L0 = 0x1_0000, L1 = 5.
        for (int b = 0; b < 2; b++)
            send(2'b10, 0, 32'h0002_8000, 32'h0003_8000, 4'h2, b == 1);
        check("m10_l0", 64'(sb[0].a[0]), 64'h2_0000);
        check("m10_l1", 64'(sb[0].a[1]), 64'hA);
        collect(0);

        // Forced close at MAX_BEATS with a mismatched beat 2.
        send(2'b01, 0, 32'h0000_0100, 32'h1, 4'h0, 0);
        send(2'b10, 0, 32'h1234_5678, 32'h0, 4'h0, 0);
        send(2'b01, 0, 32'h0000_0200, 32'h0, 4'h0, 0);
        send(2'b01, 0, 32'h0000_1000, 32'h3, 4'h0, 0);
        check("mb_value", 64'(sb[0].a[0]), 64'h1304);
        collect(0);

        // Signed overflow at 33 bits.
        send(2'b01, 1, 32'hFFFF_FFFF, 32'h0, 4'h0, 0);
        send(2'b01, 1, 32'hFFFF_FFFF, 32'h0, 4'h0, 1);
        check("ovf_model", 64'(sb[0].ovf), 64'h1);
        collect(0);

        // Reset mid-packet discards partial sums.
        send(2'b11, 0, 32'h0000_0011, 32'h0, 4'h0, 0);
        @(negedge clk);
        check("accum_partial", 64'(acc_0), 64'h11);
        rst_n = 1'b0;
        #1;
        check("mid_rst_acc_0", 64'(acc_0), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd0);
        check("mid_rst_beats", 64'(out_beats), 64'd0);
        m_active = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send(2'b11, 0, 32'h0000_0022, 32'h0, 4'h0, 1);
        collect(0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/simd_result_accumulator.md
Name: simd_result_accumulator

Overview:
- Consumer end of the SIMD multiplier result interface.
- Accepts the split result pair (result_0, result_1, result_SIDM_carry) together with the mode that produced it.
- Recombines the pair into per-lane signed/unsigned values and accumulates them over a packet of beats.
- Emits the lane sums through a valid/ready handshake. Sits between the multiplier array and the DSP output/cascade stage.

Parameters:
ACC_W, 48, width of each lane accumulator (must be >= 33).
MAX_BEATS, 256, beats after which a packet is force-closed.
CNT_W, 9, beat counter width (must satisfy 2^CNT_W > MAX_BEATS).

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  input beat valid.
in_ready  out  1  input beat accepted when in_valid & in_ready.
in_last  in  1  final beat of packet.
mode  in  2  00 16x16, 01 sum_16x16, 10 sum_8x8, 11 sum_4x4.
in_signed  in  1  a_sign|b_sign of the producing multiply.
result_0  in  32  multiplier pair word 0.
result_1  in  32  multiplier pair word 1.
result_SIDM_carry  in  4  lane extension bits.
out_valid  out  1  lane sums valid.
out_ready  in  1  downstream accept.
acc_0..acc_3  out  ACC_W each  lane sums (unused lanes zero).
out_beats  out  CNT_W  beats in emitted packet.
overflow  out  4  per-lane sticky overflow for emitted packet.
mode_err  out  1  packet saw a mode mismatch.

Behaviour:
- Reset: all outputs 0, in_ready 0 during reset and 1 in the first cycle after deassert; state IDLE. Reset mid-packet discards the partial sums.
- Lane extraction (combinational, per accepted beat):
  - mode 00/01: one lane, L0 = result_0 + result_1 (33-bit, bit 32 = result_SIDM_carry[3]).
  - mode 10: two 17-bit lanes.
    - L0 = {carry[1], result_0[15:0] + result_1[15:0]}.
    - L1 = {carry[3], result_0[31:16] + result_1[31:16]}.
    - Each 16-bit addition is truncated to 16 bits.
  - mode 11: four 9-bit lanes, Lk = {carry[k], byte k}; byte k comes from result_0 for k = 0, 2 and from result_1 for k = 1, 3.
- Extension to ACC_W: sign-extend when in_signed = 1, zero-extend otherwise.
- FSM states:
  - IDLE: first accepted beat latches mode and in_signed, loads the accumulators with the lanes, beat count = 1. Goes to HOLD if in_last, mode = 00, or MAX_BEATS = 1; otherwise ACCUM.
  - ACCUM: each accepted beat adds its lanes and increments the count. Goes to HOLD on in_last or when count reaches MAX_BEATS.
  - HOLD: out_valid = 1, outputs stable, in_ready = 0. On out_ready the FSM goes to IDLE and in_ready is 1 next cycle. There is no same-cycle bypass.
- Mode 00 is never accumulated; every beat is a one-beat packet.
- Latency: the closing beat accepted at cycle t gives out_valid at t+1.
- Overflow: set sticky per lane when the signed (or unsigned) add wraps at ACC_W. Cleared on the next packet load.
- Mode mismatch in ACCUM: the beat is accepted and its data discarded. mode_err becomes sticky for the packet and the count still increments. If the mismatched beat has in_last, the packet closes normally.
- Lanes not used by the latched mode read 0.

Decomposition:
- Shared package holds:
  - mode encodings MODE_16X16 / MODE_SUM_16X16 / MODE_SUM_8X8 / MODE_SUM_4X4;
  - FSM state typedef {IDLE, ACCUM, HOLD};
  - lane count constant 4.
- One natural sub-module: simd_result_unpack. It is combinational lane extraction plus sign/zero extension, giving four ACC_W-wide lane values and a lane-enable mask.

Test Plan:
- Mode 00, unsigned: result_0=0x0000_1234, result_1=0x0001_0000, carry=0 -> one cycle later acc_0=0x11234, out_beats=1, acc_1..3=0.
- Mode 11, signed, 3 beats: each beat has lane0 byte=0xFF, carry[0]=1 (i.e. -1), with in_last on beat 3 -> acc_0 = -3 (all-ones ACC_W except LSBs 0x...FD), out_beats=3.
- Mode 10, unsigned, 2 beats: lanes L0=0x1_0000, L1=0x0005 -> acc_0=0x2_0000, acc_1=0xA.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> in_ready=0 and outputs stable throughout; out_ready=1 -> IDLE, next packet accepted one cycle later.
- MAX_BEATS=4 with no in_last, plus a mid-packet switch from mode 01 to mode 10 on beat 2 -> forced close after beat 4, out_beats=4, mode_err=1, sum excludes beat 2.
- ACC_W=33, signed, two beats of 0x0_FFFF_FFFF (max positive) -> overflow[0]=1. Assert rst_n low in ACCUM -> all outputs 0 immediately.
